// File: rtl/sb_pkg.sv
// Shared types and helpers for the byte-granular store buffer.
// Entry widths follow SB_ADDR_W/SB_DATA_W; keep them equal to the top-level ADDR_W/DATA_W.
package sb_pkg;

  localparam int SB_ADDR_W = 32;
  localparam int SB_DATA_W = 32;
  localparam int BE_W      = SB_DATA_W / 8;
  localparam int OFS_W     = $clog2(BE_W);
  localparam int WADDR_W   = SB_ADDR_W - OFS_W;

  typedef struct packed {
    logic                 valid;
    logic [WADDR_W-1:0]   waddr;
    logic [SB_DATA_W-1:0] data;
    logic [BE_W-1:0]      be;
  } sb_entry_t;

  function automatic logic [WADDR_W-1:0] word_addr(input logic [SB_ADDR_W-1:0] addr);
    return WADDR_W'(addr >> OFS_W);
  endfunction

endpackage

// File: rtl/sb_fwd_sel.sv
// Combinational store-to-load forwarding: per byte lane, the youngest matching
// entry (searching tail-1 back to head) supplies the byte.
module sb_fwd_sel
  import sb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  sb_entry_t                    i_entries [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]     i_head,
  input  logic [$clog2(DEPTH)-1:0]     i_tail,
  input  logic [SB_ADDR_W-1:0]         i_ld_addr,
  input  logic [BE_W-1:0]              i_ld_be,
  output logic [SB_DATA_W-1:0]         o_ld_data,
  output logic [BE_W-1:0]              o_cov
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WADDR_W-1:0] w_ld_waddr;
  logic [PTR_W-1:0]   w_idx;
  logic               w_found;
  logic               w_stop;

  assign w_ld_waddr = word_addr(i_ld_addr);

  // The first hit while walking backwards from tail-1 is the youngest store for that lane.
  always_comb begin
    o_ld_data = '0;
    o_cov     = '0;
    w_idx     = '0;
    w_found   = 1'b0;
    w_stop    = 1'b0;
    for (int lane = 0; lane < BE_W; lane++) begin
      w_found = 1'b0;
      w_stop  = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        w_idx = i_tail - PTR_W'(k + 1);
        if (!w_stop && !w_found && i_entries[w_idx].valid &&
            (i_entries[w_idx].waddr == w_ld_waddr) && i_entries[w_idx].be[lane]) begin
          w_found     = 1'b1;
          o_cov[lane] = i_ld_be[lane];
          if (i_ld_be[lane]) begin
            o_ld_data[8*lane +: 8] = i_entries[w_idx].data[8*lane +: 8];
          end
        end
        if (w_idx == i_head) begin
          w_stop = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/store_buffer_ctrl.sv
// Byte-granular store buffer between MEM and the D-cache FSM: in-order drain plus load forwarding.
// Optional macro SB_COALESCE_EN merges a store into the youngest entry when the word address matches.
module store_buffer_ctrl
  import sb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  input  logic [ADDR_W-1:0]        enq_addr,
  input  logic [DATA_W-1:0]        enq_data,
  input  logic [DATA_W/8-1:0]      enq_be,
  output logic                     deq_valid,
  input  logic                     deq_ready,
  output logic [ADDR_W-1:0]        deq_addr,
  output logic [DATA_W-1:0]        deq_data,
  output logic [DATA_W/8-1:0]      deq_be,
  input  logic [ADDR_W-1:0]        ld_addr,
  input  logic [DATA_W/8-1:0]      ld_be,
  output logic [DATA_W-1:0]        ld_data,
  output logic                     ld_hit,
  output logic                     ld_partial,
  input  logic                     flush,
  output logic                     drained,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  sb_entry_t        r_entries [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic [PTR_W-1:0] w_tail_m1;
  sb_entry_t        w_head_e;
  sb_entry_t        w_last_e;
  logic             w_full;
  logic             w_deq_fire;
  logic             w_enq_fire;
  logic             w_be_nz;
  logic             w_coal_hit;
  logic             w_alloc;
  logic             w_merge;
  logic [BE_W-1:0]  w_cov;

  assign w_tail_m1  = r_tail - PTR_W'(1);
  assign w_head_e   = r_entries[r_head];
  assign w_last_e   = r_entries[w_tail_m1];
  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_be_nz    = (enq_be != '0);

  assign deq_valid  = w_head_e.valid;
  assign deq_addr   = {w_head_e.waddr, {OFS_W{1'b0}}};
  assign deq_data   = w_head_e.data;
  assign deq_be     = w_head_e.be;
  assign w_deq_fire = deq_valid && deq_ready;

`ifdef SB_COALESCE_EN
  // Merging into the head while it is leaving would lose the new bytes, so allocate instead.
  assign w_coal_hit = w_last_e.valid && (w_last_e.waddr == word_addr(enq_addr)) &&
                      !((w_tail_m1 == r_head) && w_deq_fire);
  assign enq_ready  = !flush && (!w_full || w_coal_hit);
`else
  assign w_coal_hit = 1'b0;
  assign enq_ready  = !w_full && !flush;
`endif

  assign w_enq_fire = enq_valid && enq_ready;
  assign w_alloc    = w_enq_fire && w_be_nz && !w_coal_hit;
  assign w_merge    = w_enq_fire && w_be_nz && w_coal_hit;

  assign count      = r_count;
  assign full       = w_full;
  assign drained    = (r_count == '0);

  // Head and tail never collide on a write: alloc needs a free slot, merge skips a leaving head.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_entries[k].valid <= 1'b0;
      end
    end else begin
      if (w_deq_fire) begin
        r_entries[r_head].valid <= 1'b0;
        r_head <= r_head + PTR_W'(1);
      end
      if (w_alloc) begin
        r_entries[r_tail] <= '{valid: 1'b1, waddr: word_addr(enq_addr), data: enq_data, be: enq_be};
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_merge) begin
        r_entries[w_tail_m1].be <= w_last_e.be | enq_be;
        for (int i = 0; i < BE_W; i++) begin
          if (enq_be[i]) begin
            r_entries[w_tail_m1].data[8*i +: 8] <= enq_data[8*i +: 8];
          end
        end
      end
      if (w_alloc && !w_deq_fire) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_alloc && w_deq_fire) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  sb_fwd_sel #(.DEPTH(DEPTH)) u_fwd_sel (
    .i_entries (r_entries),
    .i_head    (r_head),
    .i_tail    (r_tail),
    .i_ld_addr (ld_addr),
    .i_ld_be   (ld_be),
    .o_ld_data (ld_data),
    .o_cov     (w_cov)
  );

  assign ld_hit     = (w_cov == ld_be) && (ld_be != '0);
  assign ld_partial = (w_cov != '0) && (w_cov != ld_be);

endmodule

// File: tb/tb_store_buffer_ctrl.sv
// Randomized self-checking bench for store_buffer_ctrl against a queue-based store model.
// Honours SB_COALESCE_EN the same way the design does.
module tb_store_buffer_ctrl;

  localparam int DEPTH = 4;

  logic        clock;
  logic        reset;
  logic        enq_valid;
  logic        enq_ready;
  logic [31:0] enq_addr;
  logic [31:0] enq_data;
  logic [3:0]  enq_be;
  logic        deq_valid;
  logic        deq_ready;
  logic [31:0] deq_addr;
  logic [31:0] deq_data;
  logic [3:0]  deq_be;
  logic [31:0] ld_addr;
  logic [3:0]  ld_be;
  logic [31:0] ld_data;
  logic        ld_hit;
  logic        ld_partial;
  logic        flush;
  logic        drained;
  logic [2:0]  count;
  logic        full;

  typedef struct {
    logic [29:0] waddr;
    logic [31:0] data;
    logic [3:0]  be;
  } mEntry;

  mEntry model[$];
  int    checks = 0;
  int    errors = 0;

  store_buffer_ctrl #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clock(clock), .reset(reset),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_addr(enq_addr),
    .enq_data(enq_data), .enq_be(enq_be),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_addr(deq_addr),
    .deq_data(deq_data), .deq_be(deq_be),
    .ld_addr(ld_addr), .ld_be(ld_be), .ld_data(ld_data),
    .ld_hit(ld_hit), .ld_partial(ld_partial),
    .flush(flush), .drained(drained), .count(count), .full(full)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drive one cycle at the negedge, compare every output with the model, then advance the model.
  task automatic applyStimulus(input logic ev, input logic [31:0] ea, input logic [31:0] ed,
                               input logic [3:0] eb, input logic dr, input logic [31:0] la,
                               input logic [3:0] lb, input logic fl, input logic rs);
    int          n;
    logic        coal;
    logic        expReady;
    logic [3:0]  cov;
    logic [31:0] fwd;
    mEntry       t;
    enq_valid = ev; enq_addr = ea; enq_data = ed; enq_be = eb;
    deq_ready = dr; ld_addr = la; ld_be = lb; flush = fl; reset = rs;
    #1;
    n    = model.size();
    coal = 1'b0;
`ifdef SB_COALESCE_EN
    coal = (n > 0) && (model[n-1].waddr == ea[31:2]) && !(n == 1 && dr);
`endif
    expReady = !fl && ((n < DEPTH) || coal);
    cov = 4'b0;
    fwd = 32'b0;
    for (int l = 0; l < 4; l++) begin
      for (int j = n - 1; j >= 0; j--) begin
        if (model[j].waddr == la[31:2] && model[j].be[l]) begin
          if (lb[l]) begin
            cov[l] = 1'b1;
            fwd[8*l +: 8] = model[j].data[8*l +: 8];
          end
          break;
        end
      end
    end
    checkOutput("count", 64'(count), 64'(n));
    checkOutput("full", 64'(full), 64'(n == DEPTH));
    checkOutput("drained", 64'(drained), 64'(n == 0));
    checkOutput("enq_ready", 64'(enq_ready), 64'(expReady));
    checkOutput("deq_valid", 64'(deq_valid), 64'(n > 0));
    if (n > 0) begin
      checkOutput("deq_addr", 64'(deq_addr), 64'({model[0].waddr, 2'b00}));
      checkOutput("deq_data", 64'(deq_data), 64'(model[0].data));
      checkOutput("deq_be", 64'(deq_be), 64'(model[0].be));
    end
    checkOutput("ld_data", 64'(ld_data), 64'(fwd));
    checkOutput("ld_hit", 64'(ld_hit), 64'((cov == lb) && (lb != 0)));
    checkOutput("ld_partial", 64'(ld_partial), 64'((cov != 0) && (cov != lb)));
    if (rs) begin
      model.delete();
    end else begin
      if (ev && expReady && eb != 0 && coal) begin
        t = model[n-1];
        for (int l = 0; l < 4; l++) if (eb[l]) t.data[8*l +: 8] = ed[8*l +: 8];
        t.be = t.be | eb;
        model[n-1] = t;
      end
      if (dr && n > 0) void'(model.pop_front());
      if (ev && expReady && eb != 0 && !coal) begin
        t.waddr = ea[31:2]; t.data = ed; t.be = eb;
        model.push_back(t);
      end
    end
    @(negedge clock);
  endtask

  task automatic idleStep(input logic dr, input logic [31:0] la, input logic [3:0] lb);
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, dr, la, lb, 1'b0, 1'b0);
  endtask

  initial begin
    enq_valid = 0; enq_addr = 0; enq_data = 0; enq_be = 0;
    deq_ready = 0; ld_addr = 0; ld_be = 0; flush = 0; reset = 1;
    @(posedge clock);
    @(negedge clock);
    reset = 0;
    #1;
    checkOutput("rst_count", 64'(count), 64'd0);
    checkOutput("rst_deq_valid", 64'(deq_valid), 64'd0);
    checkOutput("rst_enq_ready", 64'(enq_ready), 64'd1);
    checkOutput("rst_full", 64'(full), 64'd0);
    checkOutput("rst_drained", 64'(drained), 64'd1);
    checkOutput("rst_ld_hit", 64'(ld_hit), 64'd0);
    checkOutput("rst_ld_partial", 64'(ld_partial), 64'd0);
    @(negedge clock);

    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 32'h10 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    checkOutput("fill_full", 64'(full), 64'd1);
    checkOutput("fill_enq_ready", 64'(enq_ready), 64'd0);
    checkOutput("fill_count", 64'(count), 64'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput("drain_order", 64'(deq_addr), 64'(32'h10 + 32'(4 * i)));
      idleStep(1'b1, 32'h0, 4'h0);
    end
    checkOutput("drain_drained", 64'(drained), 64'd1);

    applyStimulus(1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h20, 32'hAABBCCDD, 4'h1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    idleStep(1'b0, 32'h20, 4'hF);
    checkOutput("yw_ld_data", 64'(ld_data), 64'h112233DD);
    checkOutput("yw_ld_hit", 64'(ld_hit), 64'd1);
`ifdef SB_COALESCE_EN
    checkOutput("yw_count", 64'(count), 64'd1);
`else
    checkOutput("yw_count", 64'(count), 64'd2);
`endif
    repeat (2) idleStep(1'b1, 32'h0, 4'h0);

    applyStimulus(1'b1, 32'h30, 32'h0000BEEF, 4'h3, 1'b0, 32'h30, 4'hF, 1'b0, 1'b0);
    checkOutput("part_partial", 64'(ld_partial), 64'd1);
    checkOutput("part_hit", 64'(ld_hit), 64'd0);
    idleStep(1'b0, 32'h30, 4'h3);
    checkOutput("part_low_hit", 64'(ld_hit), 64'd1);
    checkOutput("part_low_data", 64'(ld_data), 64'h0000BEEF);
    idleStep(1'b1, 32'h0, 4'h0);

    applyStimulus(1'b1, 32'h50, 32'h50, 4'hF, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h54, 32'h54, 4'hF, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b1, 32'h58 + 32'(4 * i), 32'h58 + 32'(i), 4'hF, 1'b1, 32'h0, 4'h0, 1'b0, 1'b0);
    checkOutput("wrap_count", 64'(count), 64'd2);
    repeat (2) idleStep(1'b1, 32'h0, 4'h0);

    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 32'h60 + 32'(4 * i), 32'h60 + 32'(i), 4'hF, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h80, 32'h1, 4'hF, 1'b1, 32'h0, 4'h0, 1'b1, 1'b0);
      checkOutput("flush_enq_ready", 64'(enq_ready), 64'd0);
    end
    checkOutput("flush_drained", 64'(drained), 64'd1);

    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 32'h70 + 32'(4 * i), 32'h70 + 32'(i), 4'hF, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0, 4'h0, 1'b0, 1'b1);
    checkOutput("rst3_count", 64'(count), 64'd0);
    checkOutput("rst3_deq_valid", 64'(deq_valid), 64'd0);

`ifdef SB_COALESCE_EN
    applyStimulus(1'b1, 32'h40, 32'h000000AA, 4'h1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h40, 32'h0000BB00, 4'h2, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    idleStep(1'b0, 32'h0, 4'h0);
    checkOutput("coal_count", 64'(count), 64'd1);
    checkOutput("coal_data", 64'(deq_data), 64'h0000BBAA);
    checkOutput("coal_be", 64'(deq_be), 64'h3);
    idleStep(1'b1, 32'h0, 4'h0);
`endif

    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 2) != 0,
                    32'h100 + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3)),
                    $urandom,
                    4'($urandom_range(0, 15)),
                    $urandom_range(0, 1) == 1,
                    32'h100 + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3)),
                    4'($urandom_range(0, 15)),
                    $urandom_range(0, 7) == 0,
                    $urandom_range(0, 199) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
